trng_frame_rx: RTL and testbench

Receive end of the TRNG serial link. Deserialises the 8N1 line driven by the TRNG transmitter and locks onto 136-byte frames: SOF bytes 00 01 02 03, then 128 payload bytes, then 4 CRC bytes. Delivers payload bytes as they arrive, then flags each frame good or bad on CRC32-Castagnoli. Sits in the capture/loopback FPGA that checks TRNG output, and drives RTS back to the transmitter.

---
 rtl/trng_com_pkg.sv | 39 +++
 rtl/rx_byte.sv | 102 ++++++++++
 rtl/trng_frame_rx.sv | 145 ++++++++++++++
 tb/tb_trng_frame_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_com_pkg.sv
// Shared TRNG link definitions: frame layout, CRC32C constants and
// the byte-wise CRC update used by both transmit and receive sides.
package trng_com_pkg;

    localparam int PACKET_SOF_SIZE      = 4;
    localparam int PACKET_DATA_SIZE     = 128;
    localparam int PACKET_CHECKSUM_SIZE = 4;
    localparam int PACKET_SIZE          = 136;

    localparam logic [31:0] CRC32C_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32C_POLY_REFL = 32'h82F6_3B78;

    typedef enum logic [1:0] {
        PS_HUNT,
        PS_SOF,
        PS_DATA,
        PS_CRC
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [31:0] crc32c_upd(
        input logic [7:0]  d,
        input logic [31:0] c
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC32C_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling timer,
// LSB-first shift register and stop-bit check.
module rx_byte
    import trng_com_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_data,
    output logic [7:0] o_byte,
    output logic       o_strobe,
    output logic       o_framing_err
);

    localparam logic [31:0] BIT_END = 32'(CYCLES_PER_BIT);
    localparam logic [31:0] HALF_M1 = 32'((CYCLES_PER_BIT + 1) / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   line;

    rx_state_t   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        strobe_d, ferr_d;

    assign line   = sync_q[SYNC_STAGES-1];
    assign o_byte = shift_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_serial_data};
            prev_q <= line;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            o_strobe      <= 1'b0;
            o_framing_err <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            o_strobe      <= strobe_d;
            o_framing_err <= ferr_d;
        end
    end

    // Stop-bit sample returns straight to IDLE so the next start edge,
    // arriving half a bit later, is caught without a gap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !line) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d    = '0;
                    state_d  = RX_IDLE;
                    strobe_d = line;
                    ferr_d   = !line;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/trng_frame_rx.sv
// TRNG link receiver: hunts for the 00 01 02 03 SOF, streams the 128
// payload bytes and checks the trailing little-endian CRC32C.
module trng_frame_rx
    import trng_com_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_data,
    input  logic       i_hold,
    output logic       o_serial_rts_n,
    output logic [7:0] o_dat,
    output logic       o_valid,
    output logic       o_sof,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic       o_framing_err,
    output logic       o_locked
);

    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_ferr;

    rx_byte #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx_byte (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_serial_data(i_serial_data),
        .o_byte       (rx_dat),
        .o_strobe     (rx_stb),
        .o_framing_err(rx_ferr)
    );

    parse_state_t state_q, state_d;
    logic [7:0]   idx_q, idx_d;
    logic [31:0]  crc_q, crc_d;
    logic [31:0]  rcrc_q, rcrc_d;
    logic [31:0]  rx_word;
    logic [7:0]   dat_d;
    logic         valid_d, sof_d, ok_d, err_d, ferr_d, locked_d;

    assign rx_word = {rx_dat, rcrc_q[31:8]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_serial_rts_n <= 1'b1;
            state_q        <= PS_HUNT;
            idx_q          <= '0;
            crc_q          <= CRC32C_INIT;
            rcrc_q         <= '0;
            o_dat          <= '0;
            o_valid        <= 1'b0;
            o_sof          <= 1'b0;
            o_frame_ok     <= 1'b0;
            o_frame_err    <= 1'b0;
            o_framing_err  <= 1'b0;
            o_locked       <= 1'b0;
        end else begin
            o_serial_rts_n <= i_hold;
            state_q        <= state_d;
            idx_q          <= idx_d;
            crc_q          <= crc_d;
            rcrc_q         <= rcrc_d;
            o_dat          <= dat_d;
            o_valid        <= valid_d;
            o_sof          <= sof_d;
            o_frame_ok     <= ok_d;
            o_frame_err    <= err_d;
            o_framing_err  <= ferr_d;
            o_locked       <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        crc_d    = crc_q;
        rcrc_d   = rcrc_q;
        dat_d    = o_dat;
        valid_d  = 1'b0;
        sof_d    = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        ferr_d   = rx_ferr;
        locked_d = o_locked;
        if (rx_ferr) begin
            err_d    = (state_q == PS_DATA) || (state_q == PS_CRC);
            locked_d = 1'b0;
            state_d  = PS_HUNT;
            idx_d    = '0;
        end else if (rx_stb) begin
            unique case (state_q)
                PS_HUNT, PS_SOF: begin
                    if (rx_dat == idx_q) begin
                        if (idx_q == 8'(PACKET_SOF_SIZE - 1)) begin
                            sof_d    = 1'b1;
                            locked_d = 1'b1;
                            crc_d    = CRC32C_INIT;
                            idx_d    = '0;
                            state_d  = PS_DATA;
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            state_d = PS_SOF;
                        end
                    end else if (rx_dat == 8'h00) begin
                        // a stray 00 may itself open the next SOF
                        idx_d   = 8'd1;
                        state_d = PS_SOF;
                    end else begin
                        idx_d   = '0;
                        state_d = PS_HUNT;
                    end
                end
                PS_DATA: begin
                    dat_d   = rx_dat;
                    valid_d = 1'b1;
                    crc_d   = crc32c_upd(rx_dat, crc_q);
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == 8'(PACKET_DATA_SIZE - 1)) begin
                        idx_d   = '0;
                        state_d = PS_CRC;
                    end
                end
                PS_CRC: begin
                    rcrc_d = rx_word;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == 8'(PACKET_CHECKSUM_SIZE - 1)) begin
                        ok_d     = (rx_word == crc_q);
                        err_d    = (rx_word != crc_q);
                        locked_d = 1'b0;
                        idx_d    = '0;
                        state_d  = PS_HUNT;
                    end
                end
                default: state_d = PS_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_trng_frame_rx.sv
// Directed bench for trng_frame_rx: drives 8N1 frames with fractional
// bit times and checks strobes, payload order and CRC outcomes.
`timescale 1ns/1ps
module tb_trng_frame_rx;

    localparam int  CPB    = 9;
    localparam real CLK_NS = 10.0;
    localparam real BIT_NS = CLK_NS * (CPB + 1);
    localparam real GAP_NS = 20.0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic       hold = 1'b0;
    logic       rts_n;
    logic [7:0] dat;
    logic       valid, sof, fok, ferr_f, ferr_s, locked;

    int n_vec = 0;
    int n_err = 0;

    int n_valid = 0, n_sof = 0, n_ok = 0;
    int n_ferr = 0, n_fram = 0, n_both = 0;
    logic [7:0] rxq[$];

    int b_valid, b_sof, b_ok, b_ferr, b_fram, b_both, b_q;

    always #(CLK_NS / 2) clk = ~clk;

    trng_frame_rx #(
        .CYCLES_PER_BIT(CPB),
        .SYNC_STAGES   (2)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_serial_data (line),
        .i_hold        (hold),
        .o_serial_rts_n(rts_n),
        .o_dat         (dat),
        .o_valid       (valid),
        .o_sof         (sof),
        .o_frame_ok    (fok),
        .o_frame_err   (ferr_f),
        .o_framing_err (ferr_s),
        .o_locked      (locked)
    );

    always @(negedge clk) begin
        if (valid) begin
            rxq.push_back(dat);
            n_valid++;
        end
        if (sof) n_sof++;
        if (fok) n_ok++;
        if (ferr_f) n_ferr++;
        if (ferr_s) n_fram++;
        if (ferr_s && ferr_f) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] c,
                                            input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'h82F63B78 : 32'h0);
        end
        return c;
    endfunction

    task automatic mark();
        b_valid = n_valid;
        b_sof   = n_sof;
        b_ok    = n_ok;
        b_ferr  = n_ferr;
        b_fram  = n_fram;
        b_both  = n_both;
        b_q     = rxq.size();
    endtask

    task automatic send_byte(input logic [7:0] b, input real bt,
                             input bit bad_stop);
        line = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            #(bt);
        end
        line = !bad_stop;
        #(bt);
        line = 1'b1;
        if (bad_stop) #(bt);
        #(GAP_NS);
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] step,
                              input real bt, input bit with_sof,
                              input bit bad_crc, input int ferr_at);
        logic [31:0] c;
        logic [7:0]  d;
        c = 32'hFFFF_FFFF;
        if (with_sof)
            for (int i = 0; i < 4; i++) send_byte(8'(i), bt, 1'b0);
        for (int i = 0; i < 128; i++) begin
            d = base + 8'(i) * step;
            if (i == ferr_at) begin
                send_byte(d, bt, 1'b1);
                return;
            end
            send_byte(d, bt, 1'b0);
            c = ref_crc(c, d);
        end
        if (bad_crc) c[0] = ~c[0];
        for (int i = 0; i < 4; i++) send_byte(c[8*i +: 8], bt, 1'b0);
    endtask

    task automatic check_payload(input string tag, input logic [7:0] base,
                                 input logic [7:0] step, input int n);
        int errs;
        errs = 0;
        check({tag, "_count"}, 32'(rxq.size() - b_q), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (b_q + i >= rxq.size()) errs++;
            else if (rxq[b_q + i] !== base + 8'(i) * step) errs++;
        end
        check({tag, "_bad_bytes"}, 32'(errs), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        logic [7:0]  s[9];

        idle(5);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_dat", 32'(dat), 32'h00);
        check("rst_rts", 32'(rts_n), 32'd1);
        rst_n = 1'b1;
        idle(5);

        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
              8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = ref_crc(c, s[i]);
        check("model_123456789", c, 32'h1CF9_6D7C);

        // reset during a data bit of a locked frame
        for (int i = 0; i < 4; i++) send_byte(8'(i), BIT_NS, 1'b0);
        send_byte(8'h11, BIT_NS, 1'b0);
        send_byte(8'h22, BIT_NS, 1'b0);
        idle(5);
        check("pre_rst_locked", 32'(locked), 32'd1);
        check("pre_rst_dat", 32'(dat), 32'h22);
        fork
            send_byte(8'h33, BIT_NS, 1'b0);
            begin
                #(BIT_NS * 3.5);
                rst_n = 1'b0;
                #1;
                check("mid_rst_locked", 32'(locked), 32'd0);
                check("mid_rst_dat", 32'(dat), 32'h00);
                check("mid_rst_valid", 32'(valid), 32'd0);
                check("mid_rst_rts", 32'(rts_n), 32'd1);
                check("mid_rst_err", 32'(ferr_f), 32'd0);
            end
        join
        idle(10);
        rst_n = 1'b1;
        idle(10);

        // clean frame, payload 00..7F
        mark();
        send_frame(8'h00, 8'h01, BIT_NS, 1'b1, 1'b0, -1);
        idle(30);
        check("clean_sof", 32'(n_sof - b_sof), 32'd1);
        check("clean_valid", 32'(n_valid - b_valid), 32'd128);
        check_payload("clean", 8'h00, 8'h01, 128);
        check("clean_ok", 32'(n_ok - b_ok), 32'd1);
        check("clean_err", 32'(n_ferr - b_ferr), 32'd0);
        check("clean_unlocked", 32'(locked), 32'd0);

        // corrupted first CRC byte
        mark();
        send_frame(8'hA5, 8'h07, BIT_NS, 1'b1, 1'b1, -1);
        idle(30);
        check("badcrc_valid", 32'(n_valid - b_valid), 32'd128);
        check_payload("badcrc", 8'hA5, 8'h07, 128);
        check("badcrc_err", 32'(n_ferr - b_ferr), 32'd1);
        check("badcrc_ok", 32'(n_ok - b_ok), 32'd0);
        check("badcrc_fram", 32'(n_fram - b_fram), 32'd0);

        // idle-line glitch must be ignored
        mark();
        @(negedge clk);
        line = 1'b0;
        @(negedge clk);
        line = 1'b1;
        idle(40);
        check("glitch_valid", 32'(n_valid - b_valid), 32'd0);
        check("glitch_fram", 32'(n_fram - b_fram), 32'd0);

        // SOF hunt through 55 00 00 01 02 03, then a fast (-3%) frame
        mark();
        send_byte(8'h55, BIT_NS * 0.97, 1'b0);
        send_byte(8'h00, BIT_NS * 0.97, 1'b0);
        send_byte(8'h00, BIT_NS * 0.97, 1'b0);
        send_byte(8'h01, BIT_NS * 0.97, 1'b0);
        send_byte(8'h02, BIT_NS * 0.97, 1'b0);
        idle(10);
        check("hunt_no_sof_yet", 32'(n_sof - b_sof), 32'd0);
        send_byte(8'h03, BIT_NS * 0.97, 1'b0);
        idle(5);
        check("hunt_sof", 32'(n_sof - b_sof), 32'd1);
        check("hunt_locked", 32'(locked), 32'd1);
        send_frame(8'h3C, 8'h03, BIT_NS * 0.97, 1'b0, 1'b0, -1);
        idle(30);
        check("hunt_sof_once", 32'(n_sof - b_sof), 32'd1);
        check_payload("hunt", 8'h3C, 8'h03, 128);
        check("hunt_ok", 32'(n_ok - b_ok), 32'd1);
        check("hunt_err", 32'(n_ferr - b_ferr), 32'd0);

        // stop bit low on payload byte 10
        mark();
        send_frame(8'h80, 8'h01, BIT_NS, 1'b1, 1'b0, 10);
        idle(30);
        check("ferr_valid", 32'(n_valid - b_valid), 32'd10);
        check_payload("ferr", 8'h80, 8'h01, 10);
        check("ferr_fram", 32'(n_fram - b_fram), 32'd1);
        check("ferr_both", 32'(n_both - b_both), 32'd1);
        check("ferr_frame_err", 32'(n_ferr - b_ferr), 32'd1);
        check("ferr_ok", 32'(n_ok - b_ok), 32'd0);
        check("ferr_unlocked", 32'(locked), 32'd0);

        // recovery frame at a slow (+3%) bit rate
        mark();
        send_frame(8'h40, 8'h05, BIT_NS * 1.03, 1'b1, 1'b0, -1);
        idle(30);
        check("slow_sof", 32'(n_sof - b_sof), 32'd1);
        check_payload("slow", 8'h40, 8'h05, 128);
        check("slow_ok", 32'(n_ok - b_ok), 32'd1);
        check("slow_err", 32'(n_ferr - b_ferr), 32'd0);

        // RTS follows hold one clock later
        @(negedge clk);
        hold = 1'b1;
        #1;
        check("rts_before", 32'(rts_n), 32'd0);
        @(negedge clk);
        check("rts_hold", 32'(rts_n), 32'd1);
        hold = 1'b0;
        @(negedge clk);
        check("rts_release", 32'(rts_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
